fifo_ctrl_param: RTL
====================

// Module: fifo_ctrl_param
// PURPOSE
//   Pointer/flag controller for a single-clock FIFO whose storage is an external
//   simple-dual-port RAM. Next generation of the fifo_controller: any depth up to
//   2**ADDR_W with non-power-of-2 wrap, occupancy count, programmable almost
//   thresholds, qualified RAM enables, sticky overflow/underflow, synchronous clear.
// PARAMETERS
//   ADDR_W      4            RAM address width
//   DEPTH       2**ADDR_W    usable entries; legal range 2..2**ADDR_W
//   AFULL_LVL   DEPTH-2      almost_full  asserted when count >= AFULL_LVL
//   AEMPTY_LVL  2            almost_empty asserted when count <= AEMPTY_LVL
// PORTS
//   clk           in   1         clock; all state updates on rising edge
//   reset         in   1         synchronous, active-low reset
//   clear         in   1         synchronous flush; same effect as reset
//   write         in   1         write request
//   read          in   1         read request
//   write_en      out  1         write accepted this cycle (drives RAM we)
//   read_en       out  1         read accepted this cycle (drives RAM re)
//   write_addr    out  ADDR_W    RAM write address (current write pointer)
//   read_addr     out  ADDR_W    RAM read address (current read pointer)
//   count         out  ADDR_W+1  occupancy, 0..DEPTH
//   full          out  1         count == DEPTH
//   empty         out  1         count == 0
//   almost_full   out  1         count >= AFULL_LVL
//   almost_empty  out  1         count <= AEMPTY_LVL
//   overflow      out  1         sticky: a write was rejected
//   underflow     out  1         sticky: a read was rejected
// BEHAVIOUR
// - reset==0 or clear==1 at an edge: pointers=0, count=0, overflow=underflow=0;
//   reset has priority over clear; requests that cycle are ignored, not flagged.
// - Acceptance (combinational from current state and requests):
//   read_en  = read  & ~empty
//   write_en = write & (~full | read_en)   (full + read + write: both accepted)
//   empty + write + read: write accepted, read rejected (no fall-through).
// - On edge: write_en -> write_addr advances; read_en -> read_addr advances;
//   pointer at DEPTH-1 wraps to 0 (not 2**ADDR_W-1 unless DEPTH==2**ADDR_W).
// - count: +1 on write_en only, -1 on read_en only, unchanged when both/neither.
// - full/empty/almost_* decode the registered count; they change the cycle after
//   the accepting edge. Never both full and empty.
// - overflow set on edge where write & ~write_en; underflow set on edge where
//   read & ~read_en; both held until reset/clear; no effect on pointers.
// - RAM timing: data written at write_addr on edge with write_en; read data is
//   the entry at read_addr, RAM latency owned by the RAM, not this block.
// - Outputs after reset: addrs 0, count 0, empty=1, almost_empty=1, full=0,
//   almost_full=0 (unless AFULL_LVL==0), write_en/read_en follow requests.
// - Elaboration error if DEPTH<2, DEPTH>2**ADDR_W, or AFULL_LVL>DEPTH.
// TESTING  (ADDR_W=4, DEPTH=10, AFULL_LVL=8, AEMPTY_LVL=2 unless stated)
// - Reset: 2 edges reset=0 with write=1 -> addrs 0, count 0, empty=1,
//   overflow=0; reset=0 mid-fill at count 5 -> count 0 next edge.
// - Fill: 10 writes -> count 10, full=1, almost_full from count 8, write_addr
//   wrapped 9->0; 11th write -> write_en=0, overflow=1, count stays 10.
// - Drain: 10 reads from full -> read_addr wraps 9->0, empty=1, almost_empty at
//   count<=2; extra read -> read_en=0, underflow=1, count 0.
// - Simultaneous: at count 10 write+read -> both enables 1, count 10, both ptrs
//   advance; at count 0 write+read -> write_en=1, read_en=0, underflow=1, count 1.
// - Clear: count 6, overflow=1, clear=1 one cycle -> count 0, ptrs 0, flags 0.
// - Random: 2000 cycles random write/read/clear vs. reference queue model;
//   count, flags and addresses match every cycle; rerun with DEPTH=16.

Source files
------------

// File: rtl/fifo_ctrl_param.sv
// Pointer, occupancy and flag controller for a single-clock FIFO built around an
// external simple-dual-port RAM; supports non-power-of-2 depths with early wrap.
module fifo_ctrl_param #(
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 2**ADDR_W,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              write,
  input  logic              read,
  output logic              write_en,
  output logic              read_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W-1:0] read_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  if (DEPTH < 2 || DEPTH > 2**ADDR_W || AFULL_LVL > DEPTH) begin : g_bad_params
    $error("fifo_ctrl_param: illegal DEPTH or AFULL_LVL for ADDR_W");
  end

  localparam logic [ADDR_W-1:0] LAST_PTR   = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_CNT  = (ADDR_W+1)'(AFULL_LVL);
  // A threshold beyond DEPTH behaves like DEPTH; saturate so it cannot truncate.
  localparam logic [ADDR_W:0]   AEMPTY_CNT =
    (ADDR_W+1)'((AEMPTY_LVL > DEPTH) ? DEPTH : AEMPTY_LVL);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AFULL_CNT);
  assign almost_empty = (count_q <= AEMPTY_CNT);

  always_comb begin
    // A read frees a slot in the same cycle, so full still accepts write+read.
    read_en     = read & ~empty;
    write_en    = write & (~full | read_en);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q | (write & ~write_en);
    underflow_d = underflow_q | (read & ~read_en);

    if (write_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_W'(1);
    end
    if (read_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_W'(1);
    end

    case ({write_en, read_en})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign write_addr = wr_ptr_q;
  assign read_addr  = rd_ptr_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

endmodule
